pipe_vect_elastic: RTL and testbench

Elastic pipeline stage for the SIMD datapath. It registers one scalar control word plus NUM_VECT vector operands, each LANES × REG_SIZE bits, between pipeline stages. Unlike a plain enable-less stage register, it adds a valid/ready handshake, an optional 2-entry skid buffer for full throughput under backpressure, a synchronous flush, and an occupancy output. It sits between any two vector pipeline stages (e.g. decode→execute, execute→writeback).

---
 rtl/pipe_vect_pkg.sv | 23 ++
 rtl/pipe_vect_entry.sv | 33 +++
 rtl/pipe_vect_elastic.sv | 144 ++++++++++++++
 tb/tb_pipe_vect_elastic.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_vect_pkg.sv
// Shared types and constants for the elastic vector pipeline stage.
// Provides the occupancy state encoding and the default vector geometry.
package pipe_vect_pkg;

    localparam int REG_SIZE_DEF = 32;
    localparam int LANES_DEF    = 4;
    localparam int CNT_W        = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        SKIDDED = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] state_count(input state_e s);
        case (s)
            FULL:    state_count = 2'd1;
            SKIDDED: state_count = 2'd2;
            default: state_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_vect_entry.sv
// Load-enabled storage for one {ctrl, vect} entry, asynchronously cleared to 0.
// Used for both the main (output) entry and the optional skid entry.
module pipe_vect_entry #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_vect_elastic.sv
// Elastic valid/ready stage carrying a control word plus NUM_VECT vectors,
// with an optional skid entry so a registered in_ready still sustains full rate.
//
// state   | meaning
// EMPTY   | nothing held, out_valid low
// FULL    | main entry valid and driving out_*
// SKIDDED | main and skid both valid, input stalled
module pipe_vect_elastic
    import pipe_vect_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int REG_SIZE = REG_SIZE_DEF,
    parameter int LANES    = LANES_DEF,
    parameter int NUM_VECT = 3,
    parameter int SKID     = 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         flush,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [WIDTH-1:0]                             in_ctrl,
    input  logic [NUM_VECT-1:0][LANES-1:0][REG_SIZE-1:0] in_vect,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [WIDTH-1:0]                             out_ctrl,
    output logic [NUM_VECT-1:0][LANES-1:0][REG_SIZE-1:0] out_vect,
    output logic [CNT_W-1:0]                             count
);

    localparam int VW = NUM_VECT * LANES * REG_SIZE;
    localparam int DW = WIDTH + VW;

    state_e        state_q;
    state_e        state_d;
    logic          accept_in;
    logic          main_load;
    logic          main_from_skid;
    logic          skid_load;
    logic [DW-1:0] in_word;
    logic [DW-1:0] main_d_word;
    logic [DW-1:0] main_word;
    logic [DW-1:0] skid_word;

    assign in_word   = {in_ctrl, in_vect};
    assign accept_in = in_valid && in_ready;

    // Flush wins over everything; any output handshake in that cycle is simply dropped.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_in) begin
                        main_load = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (accept_in && out_ready) begin
                        main_load = 1'b1;
                    end else if (accept_in && (SKID != 0)) begin
                        skid_load = 1'b1;
                        state_d   = SKIDDED;
                    end else if (!accept_in && out_ready) begin
                        state_d = EMPTY;
                    end
                end
                SKIDDED: begin
                    if (out_ready) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_d_word = main_from_skid ? skid_word : in_word;

    pipe_vect_entry #(.DW(DW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d_word),
        .q     (main_word)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            logic in_ready_d;

            pipe_vect_entry #(.DW(DW)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_load),
                .d     (in_word),
                .q     (skid_word)
            );

            always_comb begin
                in_ready_d = (state_d != SKIDDED);
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q && !flush;
        end else begin : g_noskid
            logic skid_load_unused;

            assign skid_load_unused = skid_load;
            assign skid_word        = '0;
            assign in_ready         = (!out_valid || out_ready) && !flush;
        end
    endgenerate

    assign out_valid = (state_q != EMPTY);
    assign out_ctrl  = main_word[DW-1 -: WIDTH];
    assign out_vect  = main_word[VW-1:0];
    assign count     = state_count(state_q);

endmodule

// File: tb/tb_pipe_vect_elastic.sv
// Directed bench for pipe_vect_elastic: SKID=1, SKID=0 and a narrow-lane variant.
module tb_pipe_vect_elastic;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [7:0] ic;
        logic       ov;
        logic [7:0] oc;
        logic [1:0] cnt;
        logic       irdy;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SKID=1 instance
    logic                  a_flush = 0, a_iv = 0, a_ordy = 0;
    logic [7:0]            a_ic = 0;
    logic [2:0][3:0][31:0] a_vin = '0;
    logic                  a_irdy, a_ov;
    logic [7:0]            a_oc;
    logic [2:0][3:0][31:0] a_vout;
    logic [1:0]            a_cnt;

    // SKID=0 instance
    logic                  b_flush = 0, b_iv = 0, b_ordy = 0;
    logic [7:0]            b_ic = 0;
    logic [2:0][3:0][31:0] b_vin = '0;
    logic                  b_irdy, b_ov;
    logic [7:0]            b_oc;
    logic [2:0][3:0][31:0] b_vout;
    logic [1:0]            b_cnt;

    // NUM_VECT=1, LANES=8, REG_SIZE=16 instance
    logic                  w_flush = 0, w_iv = 0, w_ordy = 0;
    logic [7:0]            w_ic = 0;
    logic [0:0][7:0][15:0] w_vin = '0;
    logic                  w_irdy, w_ov;
    logic [7:0]            w_oc;
    logic [0:0][7:0][15:0] w_vout;
    logic [1:0]            w_cnt;

    pipe_vect_elastic #(.WIDTH(8), .REG_SIZE(32), .LANES(4), .NUM_VECT(3), .SKID(1)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_iv), .in_ready(a_irdy),
        .in_ctrl(a_ic), .in_vect(a_vin), .out_valid(a_ov), .out_ready(a_ordy),
        .out_ctrl(a_oc), .out_vect(a_vout), .count(a_cnt));

    pipe_vect_elastic #(.WIDTH(8), .REG_SIZE(32), .LANES(4), .NUM_VECT(3), .SKID(0)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_iv), .in_ready(b_irdy),
        .in_ctrl(b_ic), .in_vect(b_vin), .out_valid(b_ov), .out_ready(b_ordy),
        .out_ctrl(b_oc), .out_vect(b_vout), .count(b_cnt));

    pipe_vect_elastic #(.WIDTH(8), .REG_SIZE(16), .LANES(8), .NUM_VECT(1), .SKID(1)) u_w (
        .clk(clk), .reset(reset), .flush(w_flush), .in_valid(w_iv), .in_ready(w_irdy),
        .in_ctrl(w_ic), .in_vect(w_vin), .out_valid(w_ov), .out_ready(w_ordy),
        .out_ctrl(w_oc), .out_vect(w_vout), .count(w_cnt));

    function automatic row_t R(input logic iv, input logic ordy, input logic fl,
                               input logic [7:0] ic, input logic ov, input logic [7:0] oc,
                               input logic [1:0] cnt, input logic irdy);
        row_t r;
        r.iv = iv; r.ordy = ordy; r.fl = fl; r.ic = ic;
        r.ov = ov; r.oc = oc; r.cnt = cnt; r.irdy = irdy;
        return r;
    endfunction

    // Element [0][0] follows 0xA0.. with the ctrl word; other lanes carry a tagged pattern.
    function automatic logic [2:0][3:0][31:0] mk_vect(input logic [7:0] c);
        logic [2:0][3:0][31:0] v;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i == 0 && j == 0) v[i][j] = 32'h0000_00A0 + {24'd0, c} - 32'd1;
                else                  v[i][j] = {c, 8'(i), 8'(j), 8'h5A};
            end
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_row(input int sel, input row_t r, input string name);
        logic                  ov, irdy;
        logic [7:0]            oc;
        logic [1:0]            cnt;
        logic [2:0][3:0][31:0] vo;
        logic [2:0][3:0][31:0] vexp;
        @(negedge clk);
        if (sel == 1) begin
            a_iv = r.iv; a_ordy = r.ordy; a_flush = r.fl; a_ic = r.ic; a_vin = mk_vect(r.ic);
        end else begin
            b_iv = r.iv; b_ordy = r.ordy; b_flush = r.fl; b_ic = r.ic; b_vin = mk_vect(r.ic);
        end
        #1;
        if (sel == 1) begin
            ov = a_ov; irdy = a_irdy; oc = a_oc; cnt = a_cnt; vo = a_vout;
        end else begin
            ov = b_ov; irdy = b_irdy; oc = b_oc; cnt = b_cnt; vo = b_vout;
        end
        vexp = (r.oc == 8'd0) ? '0 : mk_vect(r.oc);
        chk({name, "_out_valid"}, 384'(ov),   384'(r.ov));
        chk({name, "_out_ctrl"},  384'(oc),   384'(r.oc));
        chk({name, "_count"},     384'(cnt),  384'(r.cnt));
        chk({name, "_in_ready"},  384'(irdy), 384'(r.irdy));
        chk({name, "_out_vect"},  384'(vo),   384'(vexp));
    endtask

    row_t ta[$];
    row_t tb[$];

    initial begin
        // SKID=1: stream, backpressure, flush in SKIDDED, flush+out_ready in SKIDDED, flush in FULL
        ta.push_back(R(1,1,0,8'h01, 0,8'h00,0,1));
        ta.push_back(R(1,1,0,8'h02, 1,8'h01,1,1));
        ta.push_back(R(1,1,0,8'h03, 1,8'h02,1,1));
        ta.push_back(R(1,1,0,8'h04, 1,8'h03,1,1));
        ta.push_back(R(0,1,0,8'h00, 1,8'h04,1,1));
        ta.push_back(R(0,1,0,8'h00, 0,8'h04,0,1));
        ta.push_back(R(1,1,0,8'h01, 0,8'h04,0,1));
        ta.push_back(R(1,1,0,8'h02, 1,8'h01,1,1));
        ta.push_back(R(1,0,0,8'h03, 1,8'h02,1,1));
        ta.push_back(R(1,0,0,8'h04, 1,8'h02,2,0));
        ta.push_back(R(1,1,0,8'h04, 1,8'h02,2,0));
        ta.push_back(R(1,1,0,8'h04, 1,8'h03,1,1));
        ta.push_back(R(0,1,0,8'h00, 1,8'h04,1,1));
        ta.push_back(R(0,1,0,8'h00, 0,8'h04,0,1));
        ta.push_back(R(1,0,0,8'h11, 0,8'h04,0,1));
        ta.push_back(R(1,0,0,8'h12, 1,8'h11,1,1));
        ta.push_back(R(1,0,1,8'h13, 1,8'h11,2,0));
        ta.push_back(R(0,0,0,8'h00, 0,8'h11,0,1));
        ta.push_back(R(1,0,0,8'h21, 0,8'h11,0,1));
        ta.push_back(R(1,0,0,8'h22, 1,8'h21,1,1));
        ta.push_back(R(1,1,1,8'h23, 1,8'h21,2,0));
        ta.push_back(R(0,1,0,8'h00, 0,8'h21,0,1));
        ta.push_back(R(1,1,0,8'h31, 0,8'h21,0,1));
        ta.push_back(R(1,0,1,8'h32, 1,8'h31,1,0));
        ta.push_back(R(0,0,0,8'h00, 0,8'h31,0,1));

        // SKID=0: same stream shape, upstream holds 0x03 until accepted
        tb.push_back(R(1,1,0,8'h01, 0,8'h00,0,1));
        tb.push_back(R(1,1,0,8'h02, 1,8'h01,1,1));
        tb.push_back(R(1,0,0,8'h03, 1,8'h02,1,0));
        tb.push_back(R(1,0,0,8'h03, 1,8'h02,1,0));
        tb.push_back(R(1,1,0,8'h03, 1,8'h02,1,1));
        tb.push_back(R(1,1,0,8'h04, 1,8'h03,1,1));
        tb.push_back(R(0,1,0,8'h00, 1,8'h04,1,1));
        tb.push_back(R(0,0,0,8'h00, 0,8'h04,0,1));
        tb.push_back(R(1,0,1,8'h05, 0,8'h04,0,0));
        tb.push_back(R(0,0,0,8'h00, 0,8'h04,0,1));

        #2;
        chk("reset_out_valid", 384'(a_ov),   384'(0));
        chk("reset_count",     384'(a_cnt),  384'(0));
        chk("reset_out_ctrl",  384'(a_oc),   384'(0));
        chk("reset_out_vect",  384'(a_vout), 384'(0));
        chk("reset_w_vect",    384'(w_vout), 384'(0));
        #10;
        reset = 1'b0;

        for (int i = 0; i < ta.size(); i++) run_row(1, ta[i], $sformatf("skid1_r%0d", i));
        for (int i = 0; i < tb.size(); i++) run_row(0, tb[i], $sformatf("skid0_r%0d", i));

        // Narrow lanes: all-ones pattern must pass bit-exact through the skid entry
        @(negedge clk);
        w_iv = 1; w_ordy = 0; w_ic = 8'h01;
        for (int j = 0; j < 8; j++) w_vin[0][j] = 16'h5A5A;
        @(negedge clk);
        w_ic = 8'hFF; w_vin = '1;
        @(negedge clk);
        w_iv = 0; w_ordy = 1; w_ic = 8'h00; w_vin = '0;
        #1;
        chk("wide_skid_count", 384'(w_cnt),  384'(2));
        chk("wide_main_ctrl",  384'(w_oc),   384'(8'h01));
        chk("wide_main_vect",  384'(w_vout), 384'({8{16'h5A5A}}));
        @(negedge clk);
        #1;
        chk("wide_ones_ctrl",  384'(w_oc),   384'(8'hFF));
        chk("wide_ones_vect",  384'(w_vout), 384'({8{16'hFFFF}}));
        chk("wide_ones_count", 384'(w_cnt),  384'(1));
        @(negedge clk);
        #1;
        chk("wide_drain_valid", 384'(w_ov),   384'(0));
        chk("wide_stale_vect",  384'(w_vout), 384'({8{16'hFFFF}}));

        // Async reset between edges while SKIDDED
        @(negedge clk);
        a_flush = 0; a_iv = 1; a_ordy = 1; a_ic = 8'h41; a_vin = mk_vect(8'h41);
        @(negedge clk);
        a_ordy = 0; a_ic = 8'h42; a_vin = mk_vect(8'h42);
        @(negedge clk);
        a_iv = 0;
        #1;
        chk("pre_rst_count", 384'(a_cnt), 384'(2));
        #1;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 384'(a_ov),      384'(0));
        chk("rst_count",     384'(a_cnt),     384'(0));
        chk("rst_out_ctrl",  384'(a_oc),      384'(0));
        chk("rst_out_vect",  384'(a_vout),    384'(0));
        chk("rst_vect_last", 384'(a_vout[2]), 384'(0));
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", 384'(a_irdy), 384'(1));
        chk("post_rst_valid",    384'(a_ov),   384'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
